data_bus_responder: RTL and testbench
=====================================

DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256: data RAM depth in 32-bit words; must be a power of two.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: console TX FIFO depth in bytes; must be a power of two, at most 8.
REQ-003 SHALL use one clock and an asynchronous, active-high reset, with ports as follows:
- clk  input  1  the single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have the remaining ports as follows:
- data_addr  input  32  byte address from the core.
- data_wdata  input  32  write data.
- data_we  input  1  write strobe.
- data_re  input  1  read strobe.
- data_rdata  output  32  read data, combinational, same cycle.
- tx_data  output  8  console byte at the FIFO head.
- tx_valid  output  1  FIFO non-empty.
- tx_ready  input  1  downstream accepts the byte.
- timer_irq  output  1  registered, set when mtime >= mtimecmp.
- halted  output  1  sticky halt flag.
- halt_code  output  8  code written to HALT.
- bus_err  output  1  registered one-cycle error pulse.

Function
REQ-005 SHALL decode addresses as follows:
- RAM: 0x0000_0000 to RAM_WORDS*4-1, word index data_addr[log2(RAM_WORDS)+1:2].
- MMIO base 0x1000_0000:
  - +0x00 CONSOLE_TX
  - +0x04 STATUS
  - +0x08 MTIME_LO
  - +0x0C MTIME_HI
  - +0x10 MTIMECMP_LO
  - +0x14 MTIMECMP_HI
  - +0x18 HALT
- All other addresses are unmapped.
REQ-006 SHALL drive data_rdata = 0 when data_re=0; otherwise data_rdata is the selected register or RAM word, using the pre-clock-edge state.
REQ-007 SHALL commit writes on the rising clk edge while data_we=1; data_we and data_re both high = write, and the read returns the old value.
REQ-008 SHALL treat an access with data_addr[1:0]!=0 as misaligned: write suppressed, read returns 0.
REQ-009 SHALL leave RAM contents unreset; RAM writes are full 32-bit words only.
REQ-010 SHALL read STATUS as {26'b0, halted, count[2:0], empty, full}.
REQ-011 SHALL read CONSOLE_TX as 0; SHALL read HALT as {23'b0, halted, halt_code}.
REQ-012 SHALL read unmapped addresses as 0 and ignore writes to them.
REQ-013 SHALL keep a 64-bit mtime counter that increments by 1 every cycle, wrapping 0xFFFF_FFFF_FFFF_FFFF to 0.
REQ-014 SHALL not increment mtime in a cycle with a write to MTIME_LO or MTIME_HI:
- MTIME_LO write loads {mtime[63:32], wdata}.
- MTIME_HI write loads {wdata, mtime[31:0]}.
REQ-015 SHALL write each half of mtimecmp independently.
REQ-016 SHALL register timer_irq each cycle as the unsigned compare (mtime >= mtimecmp) of the current values, giving one-cycle latency.
REQ-017 SHALL push data_wdata[7:0] into the FIFO tail on a CONSOLE_TX write, when count<FIFO_DEPTH or a pop occurs in the same cycle.
REQ-018 SHALL drop a CONSOLE_TX write when the FIFO is full with no simultaneous pop; count is unchanged and bus_err pulses.
REQ-019 SHALL drive tx_valid = (count!=0) and tx_data = head byte; a pop occurs on a clk edge with tx_valid && tx_ready.
REQ-020 SHALL update the FIFO on simultaneous push and pop as follows: count unchanged, order preserved, and pointers wrap modulo FIFO_DEPTH.
REQ-021 SHALL keep tx_data stable while tx_valid=1 and tx_ready=0.
REQ-022 SHALL, on any HALT write, set halted=1 and halt_code=wdata[7:0]; both stay sticky until reset, and later HALT writes are ignored.
REQ-023 SHALL, while halted=1:
- freeze mtime;
- ignore all writes;
- continue to serve reads;
- continue to drain the FIFO.
REQ-024 SHALL assert bus_err for exactly one cycle after any cycle with (data_we|data_re) to a misaligned or unmapped address, or with a dropped FIFO push.

Reset
REQ-025 SHALL, on rst=1, asynchronously clear the following:
- mtime=0
- mtimecmp=0xFFFF_FFFF_FFFF_FFFF
- FIFO pointers and count=0
- tx_valid=0, tx_data=0
- timer_irq=0
- halted=0, halt_code=0
- bus_err=0
REQ-026 SHALL, when reset is asserted mid-transfer, discard FIFO contents; a pending byte is lost and tx_valid falls immediately.
REQ-027 SHALL leave RAM contents unchanged by reset.

Verification
REQ-028 Bench SHALL cover: write 0xDEADBEEF to 0x0000_0010, then read 0x10 -> data_rdata=0xDEADBEEF in the read cycle; a same-cycle read+write returns the old value.
REQ-029 Bench SHALL cover: hold tx_ready=0 and write bytes 0x41..0x45 to CONSOLE_TX -> the first 4 are accepted, the 5th is dropped, bus_err pulses once, STATUS=0x11 (count 4, full). Then raise tx_ready -> 0x41,0x42,0x43,0x44 appear in order, and STATUS=0x02 afterwards.
REQ-030 Bench SHALL cover: write MTIMECMP_HI=0, MTIMECMP_LO=100 after reset -> timer_irq rises on the first edge after mtime reaches 100. Write MTIME_LO=0xFFFF_FFFF -> MTIME_HI increments on the next cycle.
REQ-031 Bench SHALL cover: read 0x2000_0000 and write 0x0000_0002 -> data_rdata=0, RAM unchanged, bus_err pulses one cycle after each access.
REQ-032 Bench SHALL cover: write HALT=0x5A -> halted=1, halt_code=0x5A, HALT reads 0x15A, mtime frozen, a later RAM write is ignored, and the FIFO still drains.
REQ-033 Bench SHALL cover: assert rst with 3 bytes queued and tx_ready=0 -> tx_valid=0 asynchronously, STATUS=0x02 after release, RAM data written before reset still readable.

Source files
------------

// File: rtl/data_bus_responder.sv
// Data-bus responder: word RAM plus MMIO console FIFO, 64-bit machine timer and halt latch.
// Reads are combinational from pre-edge state; writes and status flags update on the clock edge.
module data_bus_responder #(
  parameter int unsigned RAM_WORDS  = 256,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        data_we,
  input  logic        data_re,
  output logic [31:0] data_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq,
  output logic        halted,
  output logic [7:0]  halt_code,
  output logic        bus_err
);

  localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [31:0]   ram_q [RAM_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic          timer_irq_q, halted_q, halted_d, bus_err_q, bus_err_d;
  logic [7:0]    halt_code_q, halt_code_d;

  logic          aligned, ram_hit, mmio_hit, access_ok, wr_en;
  logic [2:0]    off;
  logic [AW-1:0] ram_idx;
  logic          sel_tx, sel_mtlo, sel_mthi, sel_cmplo, sel_cmphi, sel_halt;
  logic          fifo_full, fifo_empty, push_req, push, pop, drop;
  logic [2:0]    count_rd;

  assign aligned   = (data_addr[1:0] == 2'b00);
  assign ram_hit   = (data_addr[31:AW+2] == '0);
  assign off       = data_addr[4:2];
  // MMIO block is 0x1000_0000..0x1000_001F; word offset 7 is a hole.
  assign mmio_hit  = (data_addr[31:5] == 27'h080_0000) && (off != 3'd7);
  assign access_ok = aligned && (ram_hit || mmio_hit);
  assign wr_en     = data_we && access_ok && !halted_q;
  assign ram_idx   = data_addr[AW+1:2];

  assign sel_tx    = mmio_hit && (off == 3'd0);
  assign sel_mtlo  = mmio_hit && (off == 3'd2);
  assign sel_mthi  = mmio_hit && (off == 3'd3);
  assign sel_cmplo = mmio_hit && (off == 3'd4);
  assign sel_cmphi = mmio_hit && (off == 3'd5);
  assign sel_halt  = mmio_hit && (off == 3'd6);

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign count_rd   = 3'(count_q);
  assign pop        = !fifo_empty && tx_ready;
  assign push_req   = wr_en && sel_tx;
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    data_rdata = '0;
    if (data_re && access_ok) begin
      if (ram_hit) begin
        data_rdata = ram_q[ram_idx];
      end else begin
        case (off)
          3'd1:    data_rdata = {26'b0, halted_q, count_rd, fifo_empty, fifo_full};
          3'd2:    data_rdata = mtime_q[31:0];
          3'd3:    data_rdata = mtime_q[63:32];
          3'd4:    data_rdata = mtimecmp_q[31:0];
          3'd5:    data_rdata = mtimecmp_q[63:32];
          3'd6:    data_rdata = {23'b0, halted_q, halt_code_q};
          default: data_rdata = '0;
        endcase
      end
    end
  end

  always_comb begin
    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;
    halted_d    = halted_q;
    halt_code_d = halt_code_q;
    if (!halted_q) begin
      if (wr_en && sel_mtlo)      mtime_d = {mtime_q[63:32], data_wdata};
      else if (wr_en && sel_mthi) mtime_d = {data_wdata, mtime_q[31:0]};
      else                        mtime_d = mtime_q + 64'd1;
    end
    if (wr_en && sel_cmplo) mtimecmp_d[31:0]  = data_wdata;
    if (wr_en && sel_cmphi) mtimecmp_d[63:32] = data_wdata;
    if (wr_en && sel_halt) begin
      halted_d    = 1'b1;
      halt_code_d = data_wdata[7:0];
    end
  end

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    bus_err_d = ((data_we || data_re) && !access_ok) || drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      timer_irq_q <= 1'b0;
      halted_q    <= 1'b0;
      halt_code_q <= '0;
      bus_err_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      timer_irq_q <= (mtime_q >= mtimecmp_q);
      halted_q    <= halted_d;
      halt_code_q <= halt_code_d;
      bus_err_q   <= bus_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage arrays are deliberately unreset; RAM must survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && ram_hit) ram_q[ram_idx] <= data_wdata;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= data_wdata[7:0];
  end

  assign tx_valid  = !fifo_empty;
  assign tx_data   = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
  assign timer_irq = timer_irq_q;
  assign halted    = halted_q;
  assign halt_code = halt_code_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder; console bytes are tracked by a scoreboard queue.
module tb_data_bus_responder;

  localparam logic [31:0] MMIO      = 32'h1000_0000;
  localparam logic [31:0] A_TX      = MMIO + 32'h00;
  localparam logic [31:0] A_STATUS  = MMIO + 32'h04;
  localparam logic [31:0] A_MTLO    = MMIO + 32'h08;
  localparam logic [31:0] A_MTHI    = MMIO + 32'h0C;
  localparam logic [31:0] A_CMPLO   = MMIO + 32'h10;
  localparam logic [31:0] A_CMPHI   = MMIO + 32'h14;
  localparam logic [31:0] A_HALT    = MMIO + 32'h18;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_addr = '0, data_wdata = '0, data_rdata;
  logic        data_we = 1'b0, data_re = 1'b0;
  logic [7:0]  tx_data, halt_code;
  logic        tx_valid, tx_ready = 1'b0, timer_irq, halted, bus_err;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  tx_sb[$];
  logic [31:0] r, r1, r2;
  logic [63:0] m, prev_m;
  logic        got_irq;

  data_bus_responder #(.RAM_WORDS(256), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_we(data_we), .data_re(data_re), .data_rdata(data_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .timer_irq(timer_irq), .halted(halted), .halt_code(halt_code), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered and left at posedge+1; read data is sampled mid-cycle.
  task automatic access(input logic we, input logic re, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd);
    data_we = we; data_re = re; data_addr = addr; data_wdata = wd;
    #2 rd = data_rdata;
    @(posedge clk); #1;
    data_we = 1'b0; data_re = 1'b0; data_addr = '0; data_wdata = '0;
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] dummy;
    access(1'b1, 1'b0, addr, wd, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rv;
    access(1'b0, 1'b1, addr, 32'h0, rv);
    check_eq(tag, 64'(rv), 64'(exp));
  endtask

  task automatic drain(input string tag);
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!tx_valid) break;
      @(posedge clk); #1;
    end
    check_eq({tag, "_empty"}, 64'(tx_valid), 64'd0);
    check_eq({tag, "_sb_left"}, 64'(tx_sb.size()), 64'd0);
    tx_ready = 1'b0;
  endtask

  // A pop happens at the next rising edge; compare the head byte against the scoreboard.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (tx_sb.size() == 0) check_eq("tx_unexpected", 64'(tx_valid), 64'd0);
      else check_eq("tx_byte", 64'(tx_data), 64'(tx_sb.pop_front()));
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_tx_valid", 64'(tx_valid), 64'd0);
    check_eq("rst_tx_data", 64'(tx_data), 64'd0);
    check_eq("rst_irq", 64'(timer_irq), 64'd0);
    check_eq("rst_halted", 64'(halted), 64'd0);
    check_eq("rst_halt_code", 64'(halt_code), 64'd0);
    check_eq("rst_bus_err", 64'(bus_err), 64'd0);
    rst = 1'b0;
    rd_chk("rst_status", A_STATUS, 32'h02);
    rd_chk("rst_cmp_hi", A_CMPHI, 32'hFFFF_FFFF);

    // Timer compare at 100.
    bus_wr(A_CMPHI, 32'h0);
    bus_wr(A_CMPLO, 32'd100);
    data_re = 1'b1; data_addr = A_MTLO;
    prev_m = '0; m = '0; got_irq = 1'b0;
    for (int i = 0; i < 300; i++) begin
      #2 m = 64'(data_rdata);
      if (timer_irq) begin
        got_irq = 1'b1;
        break;
      end
      prev_m = m;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    data_re = 1'b0; data_addr = '0;
    check_eq("irq_rise", 64'(got_irq), 64'd1);
    check_eq("irq_prev_mtime", prev_m, 64'd100);
    check_eq("irq_mtime", m, 64'd101);

    rd_chk("mtime_hi0", A_MTHI, 32'h0);
    bus_wr(A_MTLO, 32'hFFFF_FFFF);
    rd_chk("mtime_lo_load", A_MTLO, 32'hFFFF_FFFF);
    rd_chk("mtime_hi_carry", A_MTHI, 32'h1);
    rd_chk("mtime_lo_wrap", A_MTLO, 32'h1);

    // RAM write/read and read-during-write.
    bus_wr(32'h10, 32'hDEAD_BEEF);
    rd_chk("ram_rd", 32'h10, 32'hDEAD_BEEF);
    access(1'b1, 1'b1, 32'h10, 32'h1234_5678, r);
    check_eq("ram_rw_old", 64'(r), 64'hDEAD_BEEF);
    rd_chk("ram_rd_new", 32'h10, 32'h1234_5678);

    // Unmapped and misaligned accesses.
    bus_wr(32'h0, 32'h1111_1111);
    check_eq("err_none", 64'(bus_err), 64'd0);
    access(1'b0, 1'b1, 32'h2000_0000, 32'h0, r);
    check_eq("unmapped_rd", 64'(r), 64'd0);
    check_eq("unmapped_err", 64'(bus_err), 64'd1);
    @(posedge clk); #1;
    check_eq("unmapped_err_end", 64'(bus_err), 64'd0);
    bus_wr(32'h2, 32'hCAFE_F00D);
    check_eq("misal_wr_err", 64'(bus_err), 64'd1);
    rd_chk("misal_ram_kept", 32'h0, 32'h1111_1111);
    check_eq("misal_err_end", 64'(bus_err), 64'd0);
    rd_chk("misal_rd", 32'h2, 32'h0);

    // Console FIFO overflow then drain.
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_wr(A_TX, 32'h41 + 32'(i));
      if (i < 4) tx_sb.push_back(8'(8'h41 + i));
      check_eq("fifo_push_err", 64'(bus_err), 64'(i == 4));
    end
    check_eq("fifo_head_hold", 64'(tx_data), 64'h41);
    rd_chk("fifo_status_full", A_STATUS, 32'h11);
    check_eq("fifo_err_end", 64'(bus_err), 64'd0);
    rd_chk("tx_reads_zero", A_TX, 32'h0);
    drain("fifo");
    rd_chk("fifo_status_empty", A_STATUS, 32'h02);

    // Halt: sticky, freezes timer and writes, FIFO still drains.
    bus_wr(A_TX, 32'h61); tx_sb.push_back(8'h61);
    bus_wr(A_TX, 32'h62); tx_sb.push_back(8'h62);
    bus_wr(A_HALT, 32'h5A);
    check_eq("halt_flag", 64'(halted), 64'd1);
    check_eq("halt_code", 64'(halt_code), 64'h5A);
    rd_chk("halt_rd", A_HALT, 32'h15A);
    rd_chk("halt_status", A_STATUS, 32'h28);
    access(1'b0, 1'b1, A_MTLO, 32'h0, r1);
    access(1'b0, 1'b1, A_MTLO, 32'h0, r2);
    check_eq("halt_mtime_frozen", 64'(r2), 64'(r1));
    bus_wr(32'h10, 32'h0BAD_F00D);
    rd_chk("halt_ram_kept", 32'h10, 32'h1234_5678);
    bus_wr(A_HALT, 32'h77);
    check_eq("halt_code_sticky", 64'(halt_code), 64'h5A);
    bus_wr(A_TX, 32'h63);
    rd_chk("halt_no_push", A_STATUS, 32'h28);
    drain("halt");
    check_eq("halt_still", 64'(halted), 64'd1);

    // Reset with bytes queued.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rst2_halted", 64'(halted), 64'd0);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_wr(A_TX, 32'h71 + 32'(i));
      tx_sb.push_back(8'(8'h71 + i));
    end
    check_eq("rst3_queued", 64'(tx_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst3_async_valid", 64'(tx_valid), 64'd0);
    check_eq("rst3_async_data", 64'(tx_data), 64'd0);
    tx_sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    rd_chk("rst3_status", A_STATUS, 32'h02);
    rd_chk("rst3_ram10", 32'h10, 32'h1234_5678);
    rd_chk("rst3_ram0", 32'h0, 32'h1111_1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
